// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM line controller slice.
// Provides the controller state encoding and the line/SRAM geometry constants.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned LINE_W      = 64;
  localparam int unsigned HW_PER_LINE = 4;
  localparam int unsigned SRAM_DW     = 16;

endpackage

// File: rtl/sram_acc_timer.sv
// Per-access cycle timer for the SRAM line controller.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   start     - (re)load the counter: the next cycle is the first of a new access
//   last      - the current cycle is the last cycle of the access
//   last_nxt  - value 'last' will have in the next cycle (used to register we_n)
module sram_acc_timer #(
  parameter int unsigned ACC_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic last,
  output logic last_nxt
);

  localparam int unsigned CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(ACC_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last     = (cnt == '0);
  assign last_nxt = start ? (RELOAD == '0) : (cnt <= CW'(1));

endmodule

// File: rtl/sram_line_ctrl.sv
// Memory-side stage behind the data cache.
// Read miss: fetches a 64-bit line as 4 halfword SRAM reads, then strobes line_valid.
// Store: writes one 32-bit word through to SRAM as 2 halfword writes, then strobes wr_done.
// busy freezes the pipeline for the duration of every access.
// Ports:
//   clk, rst               - clock, asynchronous active-low reset
//   rd_req, wr_req         - read-miss / store request (wr_req wins when both are set)
//   addr, wr_data          - byte address and store word, latched at request
//   busy                   - pipeline freeze
//   line_valid, line_data  - one-cycle line strobe and assembled line
//   wr_done                - one-cycle store-complete strobe
//   sram_*                 - external 16-bit SRAM interface (active-low controls)
module sram_line_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned SRAM_AW = 18,
  parameter int unsigned ACC_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_req,
  input  logic                 wr_req,
  input  logic [SRAM_AW:0]     addr,
  input  logic [31:0]          wr_data,
  output logic                 busy,
  output logic                 line_valid,
  output logic [LINE_W-1:0]    line_data,
  output logic                 wr_done,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [SRAM_DW-1:0]   sram_dq_o,
  input  logic [SRAM_DW-1:0]   sram_dq_i,
  output logic                 sram_dq_oe,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  state_t              state;
  logic [SRAM_AW-2:0]  addr_q;    // addr[SRAM_AW:2]
  logic [15:0]         wr_hi_q;
  logic [1:0]          hw;
  logic [LINE_W-1:0]   line_buf;

  logic req;
  logic acc_start;
  logic final_acc;
  logic last;
  logic last_nxt;
  logic we_n_nxt;

  // Byte offset within a word never selects a halfword.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign req  = rd_req | wr_req;
  assign busy = ((state == IDLE) && req) || (state == READ) || (state == WRITE);

  always_comb begin
    acc_start = 1'b0;
    final_acc = (state == READ) ? (hw == 2'd3) : (hw == 2'd1);
    case (state)
      IDLE:        acc_start = req;
      READ, WRITE: acc_start = last && !final_acc;
      default:     acc_start = 1'b0;
    endcase
  end

  // we_n is registered, so it is computed from the timer's next-cycle view:
  // low on all but the last cycle of a write access (always low for 1-cycle access).
  assign we_n_nxt = (ACC_CYC == 1) ? 1'b0 : last_nxt;

  sram_acc_timer #(
    .ACC_CYC (ACC_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (acc_start),
    .last     (last),
    .last_nxt (last_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wr_hi_q    <= '0;
      hw         <= '0;
      line_buf   <= '0;
      line_valid <= 1'b0;
      line_data  <= '0;
      wr_done    <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      line_valid <= 1'b0;
      wr_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q    <= addr[SRAM_AW:2];
            wr_hi_q   <= wr_data[31:16];
            hw        <= '0;
            sram_ce_n <= 1'b0;
            if (wr_req) begin
              state      <= WRITE;
              sram_addr  <= {addr[SRAM_AW:2], 1'b0};
              sram_dq_o  <= wr_data[15:0];
              sram_dq_oe <= 1'b1;
              sram_oe_n  <= 1'b1;
              sram_we_n  <= we_n_nxt;
            end else begin
              state      <= READ;
              sram_addr  <= {addr[SRAM_AW:3], 2'b00};
              sram_dq_oe <= 1'b0;
              sram_oe_n  <= 1'b0;
              sram_we_n  <= 1'b1;
            end
          end
        end

        READ: begin
          if (last) begin
            case (hw)
              2'd0:    line_buf[47:32] <= sram_dq_i;
              2'd1:    line_buf[63:48] <= sram_dq_i;
              2'd2:    line_buf[15:0]  <= sram_dq_i;
              default: ;
            endcase
            if (hw == 2'd3) begin
              state      <= DONE;
              line_valid <= 1'b1;
              line_data  <= {line_buf[63:32], sram_dq_i, line_buf[15:0]};
              sram_ce_n  <= 1'b1;
              sram_oe_n  <= 1'b1;
            end else begin
              hw        <= hw + 2'd1;
              sram_addr <= {addr_q[SRAM_AW-2:1], hw + 2'd1};
            end
          end
        end

        WRITE: begin
          if (last && hw == 2'd1) begin
            state      <= DONE;
            wr_done    <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
          end else begin
            sram_we_n <= we_n_nxt;
            if (last) begin
              hw        <= 2'd1;
              sram_addr <= {addr_q, 1'b1};
              sram_dq_o <= wr_hi_q;
            end
          end
        end

        default: state <= IDLE;  // DONE: single strobe cycle
      endcase
    end
  end

endmodule

// File: tb/tb_sram_line_ctrl.sv
// Scoreboard bench for sram_line_ctrl: one instance with ACC_CYC=2, one with ACC_CYC=1,
// each attached to a behavioural halfword SRAM.
module tb_sram_line_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd_req     [2];
  logic        wr_req     [2];
  logic [18:0] addr       [2];
  logic [31:0] wr_data    [2];
  logic        busy       [2];
  logic        line_valid [2];
  logic [63:0] line_data  [2];
  logic        wr_done    [2];
  logic [17:0] sram_addr  [2];
  logic [15:0] dq_o       [2];
  logic [15:0] dq_i       [2];
  logic        dq_oe      [2];
  logic        ce_n       [2];
  logic        oe_n       [2];
  logic        we_n       [2];

  sram_line_ctrl #(.SRAM_AW(18), .ACC_CYC(2)) u_dut_a2 (
    .clk(clk), .rst(rst), .rd_req(rd_req[0]), .wr_req(wr_req[0]), .addr(addr[0]),
    .wr_data(wr_data[0]), .busy(busy[0]), .line_valid(line_valid[0]),
    .line_data(line_data[0]), .wr_done(wr_done[0]), .sram_addr(sram_addr[0]),
    .sram_dq_o(dq_o[0]), .sram_dq_i(dq_i[0]), .sram_dq_oe(dq_oe[0]),
    .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]));

  sram_line_ctrl #(.SRAM_AW(18), .ACC_CYC(1)) u_dut_a1 (
    .clk(clk), .rst(rst), .rd_req(rd_req[1]), .wr_req(wr_req[1]), .addr(addr[1]),
    .wr_data(wr_data[1]), .busy(busy[1]), .line_valid(line_valid[1]),
    .line_data(line_data[1]), .wr_done(wr_done[1]), .sram_addr(sram_addr[1]),
    .sram_dq_o(dq_o[1]), .sram_dq_i(dq_i[1]), .sram_dq_oe(dq_oe[1]),
    .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]));

  typedef struct {
    bit          is_wr;
    logic [63:0] line;
    int          k0;
    logic [15:0] d0;
    logic [15:0] d1;
    int          lat;
    int          wel;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   strobes  [2];
  int   busy_cnt [2];
  int   wel_cnt  [2];

  // Memory contents: device view (written by DUT) and reference view (written by model).
  logic [15:0] dev_mem [int];
  logic [15:0] ref_mem [int];

  function automatic int acc(int id);
    return (id == 0) ? 2 : 1;
  endfunction

  function automatic int key(int id, logic [17:0] a);
    return id * 262144 + int'(a);
  endfunction

  function automatic logic [15:0] hw_init(int k);
    return 16'(k * 40503) ^ 16'h5a5a;
  endfunction

  function automatic logic [15:0] dev_rd(int k);
    return dev_mem.exists(k) ? dev_mem[k] : hw_init(k);
  endfunction

  function automatic logic [15:0] ref_rd(int k);
    return ref_mem.exists(k) ? ref_mem[k] : hw_init(k);
  endfunction

  // SRAM device: read data presented mid-cycle, writes taken on each clocked we_n-low cycle.
  always @(negedge clk)
    for (int id = 0; id < 2; id++) dq_i[id] = dev_rd(key(id, sram_addr[id]));

  always @(posedge clk)
    for (int id = 0; id < 2; id++)
      if (rst && !ce_n[id] && !we_n[id] && dq_oe[id]) dev_mem[key(id, sram_addr[id])] = dq_o[id];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_one(int id);
    exp_t e;
    int   qs;
    if (!rst) begin
      busy_cnt[id] = 0;
      wel_cnt[id]  = 0;
      if (id == 0) q0.delete(); else q1.delete();
      return;
    end
    if (busy[id]) busy_cnt[id]++;
    if (!we_n[id]) wel_cnt[id]++;
    if (line_valid[id] || wr_done[id]) begin
      strobes[id]++;
      qs = (id == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        chk("unexpected_strobe", 64'({line_valid[id], wr_done[id]}), 64'd0);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk("strobe_kind", 64'({line_valid[id], wr_done[id]}), e.is_wr ? 64'd1 : 64'd2);
        chk("busy_cycles", 64'(busy_cnt[id]), 64'(e.lat));
        chk("sram_idle_done", 64'({ce_n[id], oe_n[id], we_n[id], dq_oe[id]}), 64'hE);
        if (e.is_wr) begin
          chk("wr_lo_hw", 64'(dev_rd(e.k0)), 64'(e.d0));
          chk("wr_hi_hw", 64'(dev_rd(e.k0 + 1)), 64'(e.d1));
          chk("we_low_cycles", 64'(wel_cnt[id]), 64'(e.wel));
        end else begin
          chk("line_data", line_data[id], e.line);
        end
      end
      busy_cnt[id] = 0;
      wel_cnt[id]  = 0;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int id = 0; id < 2; id++) mon_one(id);
    end
  endtask

  // Expected response derived from the packing and latency rules.
  task automatic push_exp(int id, bit wr, logic [18:0] a, logic [31:0] d);
    exp_t e;
    int   k;
    e.is_wr = wr;
    e.lat   = wr ? 2 * acc(id) + 1 : 4 * acc(id) + 1;
    e.wel   = (acc(id) == 1) ? 2 : 2 * (acc(id) - 1);
    e.d0    = '0;
    e.d1    = '0;
    e.line  = '0;
    if (wr) begin
      e.k0 = key(id, {a[18:2], 1'b0});
      e.d0 = d[15:0];
      e.d1 = d[31:16];
      ref_mem[e.k0]     = e.d0;
      ref_mem[e.k0 + 1] = e.d1;
    end else begin
      k    = key(id, {a[18:3], 2'b00});
      e.k0 = k;
      e.line = {ref_rd(k + 1), ref_rd(k), ref_rd(k + 3), ref_rd(k + 2)};
    end
    if (id == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic wait_strobe(int id, int s0);
    int n = 0;
    while (strobes[id] == s0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("strobe_seen", 64'(strobes[id] - s0), 64'd1);
  endtask

  // Called 1 time unit after a rising edge; request is held for 'hold' edges.
  task automatic op(int id, bit rd, bit wr, logic [18:0] a, logic [31:0] d, int hold);
    int s0;
    push_exp(id, wr, a, d);
    s0 = strobes[id];
    rd_req[id]  = rd;
    wr_req[id]  = wr;
    addr[id]    = a;
    wr_data[id] = d;
    repeat (hold) @(posedge clk);
    #1;
    rd_req[id]  = 1'b0;
    wr_req[id]  = 1'b0;
    addr[id]    = 19'($urandom);
    wr_data[id] = $urandom;
    wait_strobe(id, s0);
  endtask

  task automatic chk_reset(int id);
    chk("rst_busy", 64'(busy[id]), 64'd0);
    chk("rst_line_valid", 64'(line_valid[id]), 64'd0);
    chk("rst_wr_done", 64'(wr_done[id]), 64'd0);
    chk("rst_line_data", line_data[id], 64'd0);
    chk("rst_sram_addr", 64'(sram_addr[id]), 64'd0);
    chk("rst_dq_o", 64'(dq_o[id]), 64'd0);
    chk("rst_ctrl", 64'({dq_oe[id], ce_n[id], oe_n[id], we_n[id]}), 64'h7);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0;
    int r;
    logic [18:0] a;
    rst = 1'b0;
    for (int id = 0; id < 2; id++) begin
      rd_req[id] = 1'b0; wr_req[id] = 1'b0; addr[id] = '0; wr_data[id] = '0;
      strobes[id] = 0; busy_cnt[id] = 0; wel_cnt[id] = 0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed read of line 0x48 with known halfwords.
    for (int i = 0; i < 4; i++) begin
      dev_mem[key(0, 18'h24 + 18'(i))] = 16'h1111 * 16'(i + 1);
      ref_mem[key(0, 18'h24 + 18'(i))] = 16'h1111 * 16'(i + 1);
    end
    op(0, 1'b1, 1'b0, 19'h00048, 32'h0, 2);
    chk("t2_line", line_data[0], 64'h2222_1111_4444_3333);

    // Directed write-through of 0xDEADBEEF at 0x4C.
    op(0, 1'b0, 1'b1, 19'h0004C, 32'hDEADBEEF, 1);
    chk("t3_sram_26", 64'(dev_rd(key(0, 18'h26))), 64'hBEEF);
    chk("t3_sram_27", 64'(dev_rd(key(0, 18'h27))), 64'hDEAD);

    // Both requests together: write only.
    op(0, 1'b1, 1'b1, 19'h00100, 32'h12345678, 3);

    // Read aborted by async reset in the middle of a cycle.
    s0 = strobes[0];
    rd_req[0] = 1'b1;
    addr[0]   = 19'h00048;
    repeat (4) @(posedge clk);
    #3;
    rst       = 1'b0;
    rd_req[0] = 1'b0;
    #1;
    chk_reset(0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_strobe", 64'(strobes[0] - s0), 64'd0);
    op(0, 1'b1, 1'b0, 19'h00048, 32'h0, 1);
    chk("t5_line", line_data[0], 64'h2222_1111_DEAD_BEEF);

    // ACC_CYC=1: request held through DONE starts a second read.
    push_exp(1, 1'b0, 19'h001F0, 32'h0);
    push_exp(1, 1'b0, 19'h001F0, 32'h0);
    s0 = strobes[1];
    rd_req[1] = 1'b1;
    addr[1]   = 19'h001F0;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_lv_T5", 64'(line_valid[1]), 64'd1);
    @(posedge clk);
    #1;
    chk("t6_busy_T6", 64'(busy[1]), 64'd1);
    chk("t6_lv_T6", 64'(line_valid[1]), 64'd0);
    @(posedge clk);
    #1;
    rd_req[1] = 1'b0;
    wait_strobe(1, s0 + 1);

    // Randomized traffic on both instances.
    for (int id = 0; id < 2; id++) begin
      for (int n = 0; n < 80; n++) begin
        r = $urandom_range(0, 2);
        a = {2'($urandom), 9'd0, 8'($urandom)};
        op(id, r != 1, r != 0, a, $urandom, $urandom_range(1, 2 * acc(id) + 1));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 64'(q0.size() + q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
